// File: rtl/ram_io_responder.sv
// ---------------------------------------------------------------------------
// ram_io_responder
//   Responder end of the CPU byte-wide memory bus. It provides a RAM of
//   2^ADDR_WIDTH bytes and a memory-mapped I/O page at 0x3xxxx:
//     0x30000 write : push a character into the output FIFO (0x00 is dropped)
//     0x30000 read  : pop the input FIFO head (empty returns 0x00)
//     0x30004 write : push 0x00 into the output FIFO and set prog_done
//     0x30004 read  : live cycle counter byte 0, and load the snapshot
//     0x30005-7 read: snapshot bytes 1..3
//   Back-pressure is applied through rdy_out, which freezes the CPU.
//
// Ports
//   clk_in    system clock
//   rst_in    synchronous active-high reset
//   cpu_a     CPU address, only [17:0] decoded
//   cpu_wr    1 = write, 0 = read
//   cpu_dout  CPU write data
//   cpu_din   registered read data, valid the cycle after the address
//   rdy_out   CPU ready, low = CPU frozen
//   tx_data   output FIFO head byte
//   tx_valid  output FIFO non-empty
//   tx_ready  sink takes tx_data this cycle
//   rx_data   incoming byte
//   rx_valid  rx_data valid
//   rx_ready  input FIFO not full
//   prog_done sticky program-stop flag
// ---------------------------------------------------------------------------
module ram_io_responder #(
  parameter int ADDR_WIDTH     = 17,
  parameter int OUT_DEPTH_LOG2 = 4,
  parameter int IN_DEPTH_LOG2  = 4
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic [31:0] cpu_a,
  input  logic        cpu_wr,
  input  logic [7:0]  cpu_dout,
  output logic [7:0]  cpu_din,
  output logic        rdy_out,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready,
  output logic        prog_done
);

  localparam int RAM_BYTES = 1 << ADDR_WIDTH;
  localparam int OUT_DEPTH = 1 << OUT_DEPTH_LOG2;
  localparam int IN_DEPTH  = 1 << IN_DEPTH_LOG2;
  localparam int OUT_CW    = OUT_DEPTH_LOG2 + 1;
  localparam int IN_CW     = IN_DEPTH_LOG2 + 1;

  localparam logic [17:0] IO_CHAR_A = 18'h30000;
  localparam logic [17:0] IO_CNT0_A = 18'h30004;
  localparam logic [17:0] IO_CNT1_A = 18'h30005;
  localparam logic [17:0] IO_CNT2_A = 18'h30006;
  localparam logic [17:0] IO_CNT3_A = 18'h30007;

  // Occupancy limit that still leaves two free slots after this cycle.
  localparam logic [OUT_CW-1:0]         OUT_RDY_MAX = OUT_CW'(OUT_DEPTH - 2);
  localparam logic [OUT_CW-1:0]         OUT_EMPTY   = {OUT_CW{1'b0}};
  localparam logic [OUT_CW-1:0]         OUT_ONE     = OUT_CW'(1);
  localparam logic [OUT_DEPTH_LOG2-1:0] OUT_PTR_ONE = OUT_DEPTH_LOG2'(1);
  localparam logic [IN_CW-1:0]          IN_FULL     = IN_CW'(IN_DEPTH);
  localparam logic [IN_CW-1:0]          IN_EMPTY    = {IN_CW{1'b0}};
  localparam logic [IN_CW-1:0]          IN_ONE      = IN_CW'(1);
  localparam logic [IN_DEPTH_LOG2-1:0]  IN_PTR_ONE  = IN_DEPTH_LOG2'(1);

  // Storage
  logic [7:0] ram_mem [RAM_BYTES];
  logic [7:0] out_mem [OUT_DEPTH];
  logic [7:0] in_mem  [IN_DEPTH];

  // Registers
  logic [7:0]                cpu_din_q;
  logic                      rdy_q;
  logic                      prog_done_q;
  logic                      tx_valid_q;
  logic                      rx_ready_q;
  logic                      run_q;       // previous cycle was a serviced read of 0x30000
  logic [31:0]               cnt_q;
  logic [31:0]               snap_q;
  logic [OUT_DEPTH_LOG2-1:0] out_rd_ptr_q;
  logic [OUT_DEPTH_LOG2-1:0] out_wr_ptr_q;
  logic [OUT_CW-1:0]         out_cnt_q;
  logic [IN_DEPTH_LOG2-1:0]  in_rd_ptr_q;
  logic [IN_DEPTH_LOG2-1:0]  in_wr_ptr_q;
  logic [IN_CW-1:0]          in_cnt_q;

  // Next-state / combinational signals
  logic [17:0]           bus_a_s;
  logic [ADDR_WIDTH-1:0] ram_idx_s;
  logic                  is_io_s;
  logic                  svc_s;
  logic                  ram_wr_s;
  logic                  ram_rd_s;
  logic                  io_wr_s;
  logic                  io_rd_s;
  logic                  out_push_s;
  logic [7:0]            out_push_data_s;
  logic                  stop_s;
  logic                  out_pop_s;
  logic [OUT_CW-1:0]     out_cnt_d;
  logic                  prog_done_d;
  logic                  rdy_d;
  logic                  in_push_s;
  logic                  rd_char_s;
  logic                  in_pop_s;
  logic [IN_CW-1:0]      in_cnt_d;
  logic                  rx_ready_d;
  logic [7:0]            io_din_s;
  logic                  snap_ld_s;
  logic                  unused_s;

  assign unused_s = ^cpu_a[31:18];

  // Bus decode; nothing is serviced while frozen or in reset.
  assign bus_a_s   = cpu_a[17:0];
  assign ram_idx_s = cpu_a[ADDR_WIDTH-1:0];
  assign is_io_s   = (bus_a_s[17:16] == 2'b11);
  assign svc_s     = rdy_q & ~rst_in;
  assign ram_wr_s  = svc_s &  cpu_wr & ~is_io_s;
  assign ram_rd_s  = svc_s & ~cpu_wr & ~is_io_s;
  assign io_wr_s   = svc_s &  cpu_wr &  is_io_s;
  assign io_rd_s   = svc_s & ~cpu_wr &  is_io_s;

  // Output FIFO push source: character writes and the program-stop marker.
  always_comb begin
    out_push_s      = 1'b0;
    out_push_data_s = cpu_dout;
    stop_s          = 1'b0;
    if (io_wr_s) begin
      case (bus_a_s)
        IO_CHAR_A: begin
          out_push_s      = (cpu_dout != 8'h00);
          out_push_data_s = cpu_dout;
        end
        IO_CNT0_A: begin
          out_push_s      = 1'b1;
          out_push_data_s = 8'h00;
          stop_s          = 1'b1;
        end
        default: begin
          out_push_s      = 1'b0;
          out_push_data_s = cpu_dout;
        end
      endcase
    end else begin
      out_push_s = 1'b0;
    end
  end

  // Output FIFO occupancy and the back-pressure decision for next cycle.
  always_comb begin
    out_pop_s = tx_valid_q & tx_ready & ~rst_in;
    out_cnt_d = out_cnt_q;
    if (out_push_s && !out_pop_s) begin
      out_cnt_d = out_cnt_q + OUT_ONE;
    end else if (out_pop_s && !out_push_s) begin
      out_cnt_d = out_cnt_q - OUT_ONE;
    end else begin
      out_cnt_d = out_cnt_q;
    end
    prog_done_d = prog_done_q | stop_s;
    rdy_d       = (out_cnt_d <= OUT_RDY_MAX) & ~prog_done_d;
  end

  // Input FIFO: pop only on the first cycle of a run of 0x30000 reads.
  always_comb begin
    in_push_s = rx_valid & rx_ready_q & ~rst_in;
    rd_char_s = io_rd_s & (bus_a_s == IO_CHAR_A);
    in_pop_s  = rd_char_s & ~run_q & (in_cnt_q != IN_EMPTY);
    in_cnt_d  = in_cnt_q;
    if (in_push_s && !in_pop_s) begin
      in_cnt_d = in_cnt_q + IN_ONE;
    end else if (in_pop_s && !in_push_s) begin
      in_cnt_d = in_cnt_q - IN_ONE;
    end else begin
      in_cnt_d = in_cnt_q;
    end
    rx_ready_d = (in_cnt_d != IN_FULL);
  end

  // I/O read data; byte 0 of the counter comes live, the rest from the snapshot.
  always_comb begin
    io_din_s  = cpu_din_q;
    snap_ld_s = 1'b0;
    if (io_rd_s) begin
      case (bus_a_s)
        IO_CHAR_A: begin
          if (run_q) begin
            io_din_s = cpu_din_q;
          end else if (in_cnt_q != IN_EMPTY) begin
            io_din_s = in_mem[in_rd_ptr_q];
          end else begin
            io_din_s = 8'h00;
          end
        end
        IO_CNT0_A: begin
          io_din_s  = cnt_q[7:0];
          snap_ld_s = 1'b1;
        end
        IO_CNT1_A: io_din_s = snap_q[15:8];
        IO_CNT2_A: io_din_s = snap_q[23:16];
        IO_CNT3_A: io_din_s = snap_q[31:24];
        default:   io_din_s = 8'h00;
      endcase
    end else begin
      io_din_s = cpu_din_q;
    end
  end

  // RAM write port (contents deliberately survive reset).
  always_ff @(posedge clk_in) begin
    if (ram_wr_s) begin
      ram_mem[ram_idx_s] <= cpu_dout;
    end
  end

  // Registered read data: RAM byte, I/O byte, or hold.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cpu_din_q <= 8'h00;
    end else if (ram_rd_s) begin
      cpu_din_q <= ram_mem[ram_idx_s];
    end else begin
      cpu_din_q <= io_din_s;
    end
  end

  // FIFO data storage; pointers are reset elsewhere so contents need no reset.
  always_ff @(posedge clk_in) begin
    if (out_push_s) begin
      out_mem[out_wr_ptr_q] <= out_push_data_s;
    end
    if (in_push_s) begin
      in_mem[in_wr_ptr_q] <= rx_data;
    end
  end

  // Output FIFO pointers, occupancy and flags.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      out_rd_ptr_q <= {OUT_DEPTH_LOG2{1'b0}};
      out_wr_ptr_q <= {OUT_DEPTH_LOG2{1'b0}};
      out_cnt_q    <= OUT_EMPTY;
      tx_valid_q   <= 1'b0;
      rdy_q        <= 1'b0;
      prog_done_q  <= 1'b0;
    end else begin
      if (out_push_s) begin
        out_wr_ptr_q <= out_wr_ptr_q + OUT_PTR_ONE;
      end
      if (out_pop_s) begin
        out_rd_ptr_q <= out_rd_ptr_q + OUT_PTR_ONE;
      end
      out_cnt_q   <= out_cnt_d;
      tx_valid_q  <= (out_cnt_d != OUT_EMPTY);
      rdy_q       <= rdy_d;
      prog_done_q <= prog_done_d;
    end
  end

  // Input FIFO pointers, occupancy, ready flag and read-run tracking.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      in_rd_ptr_q <= {IN_DEPTH_LOG2{1'b0}};
      in_wr_ptr_q <= {IN_DEPTH_LOG2{1'b0}};
      in_cnt_q    <= IN_EMPTY;
      rx_ready_q  <= 1'b0;
      run_q       <= 1'b0;
    end else begin
      if (in_push_s) begin
        in_wr_ptr_q <= in_wr_ptr_q + IN_PTR_ONE;
      end
      if (in_pop_s) begin
        in_rd_ptr_q <= in_rd_ptr_q + IN_PTR_ONE;
      end
      in_cnt_q   <= in_cnt_d;
      rx_ready_q <= rx_ready_d;
      run_q      <= rd_char_s;
    end
  end

  // Free-running cycle counter and its coherent snapshot.
  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      cnt_q  <= 32'h0000_0000;
      snap_q <= 32'h0000_0000;
    end else begin
      cnt_q <= cnt_q + 32'h0000_0001;
      if (snap_ld_s) begin
        snap_q <= cnt_q;
      end
    end
  end

  assign cpu_din   = cpu_din_q;
  assign rdy_out   = rdy_q;
  assign tx_data   = out_mem[out_rd_ptr_q];
  assign tx_valid  = tx_valid_q;
  assign rx_ready  = rx_ready_q;
  assign prog_done = prog_done_q;

endmodule

// File: tb/tb_ram_io_responder.sv
module tb_ram_io_responder;

  logic        clk_in = 1'b0;
  logic        rst_in;
  logic [31:0] cpu_a;
  logic        cpu_wr;
  logic [7:0]  cpu_dout;
  logic [7:0]  cpu_din;
  logic        rdy_out;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        prog_done;

  ram_io_responder dut (
    .clk_in(clk_in), .rst_in(rst_in), .cpu_a(cpu_a), .cpu_wr(cpu_wr),
    .cpu_dout(cpu_dout), .cpu_din(cpu_din), .rdy_out(rdy_out),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
    .prog_done(prog_done)
  );

  always #5 clk_in = ~clk_in;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural reference: queues for FIFOs, sparse array for RAM.
  logic [7:0]  m_ram [int];
  logic [7:0]  out_q [$];
  logic [7:0]  in_q  [$];
  logic [7:0]  m_din;
  bit          m_din_ok;
  bit          m_rdy, m_rxr, m_done, m_run;
  logic [31:0] m_cnt, m_snap;
  logic        g_txr;

  typedef struct {
    logic [31:0] a;
    logic        wr;
    logic [7:0]  dout;
    logic        chk;
    logic [7:0]  exp;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step(input logic rst, input logic [31:0] a, input logic wr,
                            input logic [7:0] dout, input logic txr,
                            input logic rxv, input logic [7:0] rxd);
    logic [17:0] a18;
    bit svc, io, rx_push;
    int idx;
    a18 = a[17:0];
    idx = int'(a[16:0]);
    if (rst) begin
      out_q.delete(); in_q.delete();
      m_din = 8'h00; m_din_ok = 1'b1;
      m_rdy = 1'b0; m_rxr = 1'b0; m_done = 1'b0; m_run = 1'b0;
      m_cnt = 32'h0; m_snap = 32'h0;
      return;
    end
    svc = m_rdy;
    io  = (a18[17:16] == 2'b11);
    rx_push = rxv && m_rxr;
    if (out_q.size() != 0 && txr) void'(out_q.pop_front());
    if (svc) begin
      if (wr) begin
        if (!io) m_ram[idx] = dout;
        else if (a18 == 18'h30000) begin
          if (dout != 8'h00) out_q.push_back(dout);
        end else if (a18 == 18'h30004) begin
          out_q.push_back(8'h00);
          m_done = 1'b1;
        end
      end else if (!io) begin
        if (m_ram.exists(idx)) begin m_din = m_ram[idx]; m_din_ok = 1'b1; end
        else m_din_ok = 1'b0;
      end else begin
        m_din_ok = 1'b1;
        case (a18)
          18'h30000: if (!m_run) m_din = (in_q.size() != 0) ? in_q.pop_front() : 8'h00;
          18'h30004: begin m_din = m_cnt[7:0]; m_snap = m_cnt; end
          18'h30005: m_din = m_snap[15:8];
          18'h30006: m_din = m_snap[23:16];
          18'h30007: m_din = m_snap[31:24];
          default:   m_din = 8'h00;
        endcase
      end
    end
    if (rx_push) in_q.push_back(rxd);
    m_run = svc && !wr && (a18 == 18'h30000);
    m_cnt = m_cnt + 32'd1;
    m_rdy = ((16 - out_q.size()) >= 2) && !m_done;
    m_rxr = (in_q.size() < 16);
  endtask

  task automatic check_outputs();
    chk("rdy_out", {31'd0, rdy_out}, {31'd0, m_rdy});
    chk("rx_ready", {31'd0, rx_ready}, {31'd0, m_rxr});
    chk("prog_done", {31'd0, prog_done}, {31'd0, m_done});
    chk("tx_valid", {31'd0, tx_valid}, (out_q.size() != 0) ? 32'd1 : 32'd0);
    if (out_q.size() != 0) chk("tx_data", {24'd0, tx_data}, {24'd0, out_q[0]});
    if (m_din_ok) chk("cpu_din", {24'd0, cpu_din}, {24'd0, m_din});
  endtask

  task automatic step(input logic rst, input logic [31:0] a, input logic wr,
                      input logic [7:0] dout, input logic txr,
                      input logic rxv, input logic [7:0] rxd);
    rst_in = rst; cpu_a = a; cpu_wr = wr; cpu_dout = dout;
    tx_ready = txr; rx_valid = rxv; rx_data = rxd;
    @(posedge clk_in);
    model_step(rst, a, wr, dout, txr, rxv, rxd);
    #1;
    check_outputs();
  endtask

  task automatic idle();                      step(1'b0, 32'h30008, 1'b0, 8'h00, g_txr, 1'b0, 8'h00); endtask
  task automatic bus_wr(input logic [31:0] a, input logic [7:0] d); step(1'b0, a, 1'b1, d, g_txr, 1'b0, 8'h00); endtask
  task automatic bus_rd(input logic [31:0] a); step(1'b0, a, 1'b0, 8'h00, g_txr, 1'b0, 8'h00); endtask
  task automatic do_reset();                  step(1'b1, 32'h0, 1'b0, 8'h00, g_txr, 1'b0, 8'h00); endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] r;
    logic [31:0] a;
    r = $urandom;
    case ($urandom_range(0, 5))
      0, 1: begin
        a = 32'h0000_0100 | (r & 32'h0000_000F);
        if (r[8]) a = a | 32'h0002_0000;
        if (r[9]) a = a | 32'hFF00_0000;
      end
      2, 3: a = 32'h0003_0000;
      4:    a = 32'h0003_0004 + 32'($urandom_range(0, 3));
      default: a = 32'h0003_0008 + (r & 32'h0000_000F);
    endcase
    return a;
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0]  got [$];
    logic [7:0]  expq [$];
    logic [7:0]  b0, b1, b2, b3;
    logic [31:0] ra;
    logic        rw;
    int          nwr;

    tbl[0]  = '{32'h0000_0123, 1'b1, 8'hA5, 1'b0, 8'h00};
    tbl[1]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'hA5};
    tbl[2]  = '{32'h0002_0123, 1'b1, 8'h3C, 1'b1, 8'hA5};
    tbl[3]  = '{32'h0000_0123, 1'b0, 8'h00, 1'b1, 8'h3C};
    tbl[4]  = '{32'hFFFC_0123, 1'b0, 8'h00, 1'b1, 8'h3C};
    tbl[5]  = '{32'h0000_5555, 1'b1, 8'h5A, 1'b1, 8'h3C};
    tbl[6]  = '{32'hABC0_5555, 1'b0, 8'h00, 1'b1, 8'h5A};
    tbl[7]  = '{32'h0003_0008, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[8]  = '{32'h0003_000C, 1'b1, 8'h77, 1'b1, 8'h00};
    tbl[9]  = '{32'h0001_FFFF, 1'b1, 8'hEE, 1'b1, 8'h00};
    tbl[10] = '{32'h0001_FFFF, 1'b0, 8'h00, 1'b1, 8'hEE};
    tbl[11] = '{32'h0003_FFFF, 1'b0, 8'h00, 1'b1, 8'h00};
    tbl[12] = '{32'h0003_0001, 1'b0, 8'h00, 1'b1, 8'h00};

    g_txr = 1'b0;
    do_reset();
    do_reset();
    chk("reset_cpu_din", {24'd0, cpu_din}, 32'h00);
    chk("reset_rdy", {31'd0, rdy_out}, 32'd0);
    idle();
    chk("rdy_after_release", {31'd0, rdy_out}, 32'd1);

    // RAM round trip, aliasing and misc I/O
    for (int i = 0; i < 13; i++) begin
      step(1'b0, tbl[i].a, tbl[i].wr, tbl[i].dout, 1'b0, 1'b0, 8'h00);
      if (tbl[i].chk) chk($sformatf("tbl%0d_cpu_din", i), {24'd0, cpu_din}, {24'd0, tbl[i].exp});
    end

    // Output path: 0x00 dropped, fill until back-pressure, then drain
    bus_wr(32'h30000, 8'h48);
    bus_wr(32'h30000, 8'h00);
    bus_wr(32'h30000, 8'h69);
    chk("tx_head_H", {24'd0, tx_data}, 32'h48);
    nwr = 0;
    for (int k = 0; k < 40 && rdy_out; k++) begin
      bus_wr(32'h30000, 8'(8'h10 + nwr));
      nwr++;
    end
    chk("fill_writes_until_rdy_low", nwr, 13);
    chk("rdy_low_when_full", {31'd0, rdy_out}, 32'd0);
    expq = '{8'h48, 8'h69};
    for (int k = 0; k < 13; k++) expq.push_back(8'(8'h10 + k));
    g_txr = 1'b1;
    for (int k = 0; k < 40 && tx_valid; k++) begin
      got.push_back(tx_data);
      idle();
    end
    chk("drain_count", got.size(), 15);
    for (int k = 0; k < 15 && k < got.size(); k++)
      chk($sformatf("drain_byte%0d", k), {24'd0, got[k]}, {24'd0, expq[k]});
    chk("rdy_back_high", {31'd0, rdy_out}, 32'd1);

    // Input path: single pop per run, then empty read
    step(1'b0, 32'h30008, 1'b0, 8'h00, g_txr, 1'b1, 8'h41);
    step(1'b0, 32'h30008, 1'b0, 8'h00, g_txr, 1'b1, 8'h42);
    for (int k = 0; k < 3; k++) begin
      bus_rd(32'h30000);
      chk($sformatf("run_read%0d", k), {24'd0, cpu_din}, 32'h41);
    end
    idle();
    bus_rd(32'h30000);
    chk("second_read", {24'd0, cpu_din}, 32'h42);
    idle();
    bus_rd(32'h30000);
    chk("empty_read", {24'd0, cpu_din}, 32'h00);
    for (int k = 0; k < 17; k++) step(1'b0, 32'h30008, 1'b0, 8'h00, g_txr, 1'b1, 8'(8'h60 + k));
    chk("rx_full", {31'd0, rx_ready}, 32'd0);
    for (int k = 0; k < 16; k++) begin
      bus_rd(32'h30000);
      chk($sformatf("rx_drain%0d", k), {24'd0, cpu_din}, {24'd0, 8'(8'h60 + k)});
      idle();
    end
    step(1'b0, 32'h30000, 1'b0, 8'h00, g_txr, 1'b1, 8'h99);
    chk("push_on_empty_read", {24'd0, cpu_din}, 32'h00);
    idle();
    bus_rd(32'h30000);
    chk("push_on_empty_kept", {24'd0, cpu_din}, 32'h99);

    // Counter coherency: cycle 0 is the first cycle after reset release
    do_reset();
    for (int t = 0; t < 32'h1FE; t++) idle();
    bus_rd(32'h30004); b0 = cpu_din;
    chk("cnt_byte0", {24'd0, b0}, 32'hFE);
    idle(); idle(); idle();
    bus_rd(32'h30005); b1 = cpu_din;
    idle();
    bus_rd(32'h30006); b2 = cpu_din;
    bus_rd(32'h30007); b3 = cpu_din;
    chk("cnt_snapshot", {b3, b2, b1, b0}, 32'h0000_01FE);

    // Randomised traffic against the model
    ra = 32'h30008; rw = 1'b0;
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 3) != 0) begin
        ra = pick_addr();
        rw = ($urandom_range(0, 2) == 0);
        if (ra[17:0] >= 18'h30004 && ra[17:0] <= 18'h30007) rw = 1'b0;
      end
      step(1'b0, ra, rw, ($urandom_range(0, 7) == 0) ? 8'h00 : 8'($urandom),
           1'($urandom_range(0, 1)), ($urandom_range(0, 2) == 0), 8'($urandom));
    end

    // Program stop
    g_txr = 1'b0;
    do_reset();
    idle();
    bus_wr(32'h30004, 8'h55);
    chk("stop_done", {31'd0, prog_done}, 32'd1);
    chk("stop_rdy", {31'd0, rdy_out}, 32'd0);
    chk("stop_tx_valid", {31'd0, tx_valid}, 32'd1);
    chk("stop_tx_data", {24'd0, tx_data}, 32'h00);
    for (int k = 0; k < 3; k++) begin
      bus_wr(32'h00123, 8'hFF);
      bus_wr(32'h30000, 8'h5A);
    end
    g_txr = 1'b1;
    idle();
    chk("stop_no_extra_tx", {31'd0, tx_valid}, 32'd0);
    chk("stop_rdy_stays_low", {31'd0, rdy_out}, 32'd0);
    g_txr = 1'b0;
    do_reset();
    idle();
    bus_rd(32'h00123);
    chk("ram_untouched_after_stop", {24'd0, cpu_din}, 32'h3C);

    // Reset mid-operation with both FIFOs loaded
    for (int k = 0; k < 5; k++)
      step(1'b0, 32'h30000, 1'b1, 8'(k + 1), 1'b0, 1'b1, 8'(8'h50 + k));
    step(1'b0, 32'h30008, 1'b0, 8'h00, 1'b0, 1'b1, 8'h55);
    bus_rd(32'h30000);
    chk("pre_reset_read", {24'd0, cpu_din}, 32'h50);
    step(1'b1, 32'h30000, 1'b0, 8'h00, 1'b0, 1'b1, 8'h77);
    chk("rst_tx_valid", {31'd0, tx_valid}, 32'd0);
    chk("rst_cpu_din", {24'd0, cpu_din}, 32'h00);
    chk("rst_rdy", {31'd0, rdy_out}, 32'd0);
    chk("rst_prog_done", {31'd0, prog_done}, 32'd0);
    chk("rst_rx_ready", {31'd0, rx_ready}, 32'd0);
    idle();
    chk("release_rdy", {31'd0, rdy_out}, 32'd1);
    chk("release_rx_ready", {31'd0, rx_ready}, 32'd1);
    bus_rd(32'h30000);
    chk("rst_discarded_rx", {24'd0, cpu_din}, 32'h00);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
